// File: rtl/cprv_pkg.sv
// Shared pipeline package: dmem arbiter FSM states, picker width and the load/store encodings.
package cprv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } dmem_arb_state_t;

    // Number of ports the 2-way picker serves.
    localparam int unsigned ARB_PORTS = 2;

    // Store-enable encoding used on every dmem request channel.
    localparam logic OP_LOAD  = 1'b0;
    localparam logic OP_STORE = 1'b1;

endpackage

// File: rtl/cprv_dmem_arbiter_if.sv
// Bus bundle around the dmem arbiter: requester-side channels plus the dmem-side channels.
// The slave modport is the arbiter's view; master is the view of the requesters and the dmem.
interface cprv_dmem_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned NUM_REQ    = 2
);

    // Requester side
    logic [NUM_REQ-1:0]                 valid_req_i;
    logic [NUM_REQ-1:0]                 ready_req_o;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] addr_req_i;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] wdata_req_i;
    logic [NUM_REQ-1:0]                 w_en_req_i;
    logic [NUM_REQ-1:0]                 valid_rsp_o;
    logic [NUM_REQ-1:0]                 ready_rsp_i;
    logic [DATA_WIDTH-1:0]              rdata_rsp_o;

    // dmem side
    logic                               valid_dmem_o;
    logic                               ready_dmem_i;
    logic [DATA_WIDTH-1:0]              addr_dmem_o;
    logic [DATA_WIDTH-1:0]              wdata_dmem_o;
    logic                               w_en_dmem_o;
    logic                               valid_dmem_rsp_i;
    logic                               ready_dmem_rsp_o;
    logic [DATA_WIDTH-1:0]              rdata_dmem_i;

    modport slave (
        input  valid_req_i, addr_req_i, wdata_req_i, w_en_req_i, ready_rsp_i,
        output ready_req_o, valid_rsp_o, rdata_rsp_o,
        input  ready_dmem_i, valid_dmem_rsp_i, rdata_dmem_i,
        output valid_dmem_o, addr_dmem_o, wdata_dmem_o, w_en_dmem_o, ready_dmem_rsp_o
    );

    modport master (
        output valid_req_i, addr_req_i, wdata_req_i, w_en_req_i, ready_rsp_i,
        input  ready_req_o, valid_rsp_o, rdata_rsp_o,
        output ready_dmem_i, valid_dmem_rsp_i, rdata_dmem_i,
        input  valid_dmem_o, addr_dmem_o, wdata_dmem_o, w_en_dmem_o, ready_dmem_rsp_o
    );

endinterface

// File: rtl/cprv_arb_pick.sv
// Combinational 2-way request picker.
// CPRV_DMEM_ARB_RR_EN defined: on contention the port equal to rr_ptr_i wins.
// Undefined: fixed priority, port 0 highest, and there is no rr_ptr_i port.
module cprv_arb_pick
    import cprv_pkg::*;
(
    input  logic [ARB_PORTS-1:0] valid_i,
`ifdef CPRV_DMEM_ARB_RR_EN
    input  logic                 rr_ptr_i,
`endif
    output logic [ARB_PORTS-1:0] gnt_o,
    output logic                 gnt_idx_o
);

    // Select the winning index, then expand to one-hot only when something is valid.
    always_comb begin
        gnt_idx_o = 1'b0;
        gnt_o     = '0;
`ifdef CPRV_DMEM_ARB_RR_EN
        if (valid_i == 2'b11) begin
            gnt_idx_o = rr_ptr_i;
        end else if (valid_i[1]) begin
            gnt_idx_o = 1'b1;
        end
`else
        if (!valid_i[0] && valid_i[1]) begin
            gnt_idx_o = 1'b1;
        end
`endif
        if (|valid_i) begin
            gnt_o[gnt_idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/cprv_dmem_arbiter.sv
// Shares one dmem port between the mem stage (port 0) and a secondary master (port 1).
// One transaction in flight at a time: IDLE accepts, ISSUE drives dmem, RESP returns data.
// Optional round-robin arbitration is enabled with CPRV_DMEM_ARB_RR_EN.
module cprv_dmem_arbiter
    import cprv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned NUM_REQ    = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    cprv_dmem_arbiter_if.slave      bus
);

    dmem_arb_state_t       state_q, state_d;
    logic                  grant_q, grant_d;
    logic                  valid_dmem_q, valid_dmem_d;
    logic                  w_en_q, w_en_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

    logic [NUM_REQ-1:0]    pick_gnt;
    logic                  pick_idx;

`ifdef CPRV_DMEM_ARB_RR_EN
    logic                  rr_ptr_q, rr_ptr_d;
`endif

    cprv_arb_pick u_pick (
        .valid_i   (bus.valid_req_i),
`ifdef CPRV_DMEM_ARB_RR_EN
        .rr_ptr_i  (rr_ptr_q),
`endif
        .gnt_o     (pick_gnt),
        .gnt_idx_o (pick_idx)
    );

    // Next-state logic plus the combinational handshake outputs.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        valid_dmem_d = valid_dmem_q;
        w_en_d       = w_en_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
`ifdef CPRV_DMEM_ARB_RR_EN
        rr_ptr_d     = rr_ptr_q;
`endif
        bus.ready_req_o      = '0;
        bus.valid_rsp_o      = '0;
        bus.ready_dmem_rsp_o = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (|bus.valid_req_i) begin
                    bus.ready_req_o = pick_gnt;
                    // Payload is captured only here; later requester changes are ignored.
                    addr_d       = bus.addr_req_i[pick_idx];
                    wdata_d      = bus.wdata_req_i[pick_idx];
                    w_en_d       = bus.w_en_req_i[pick_idx];
                    valid_dmem_d = 1'b1;
                    grant_d      = pick_idx;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                if (valid_dmem_q && bus.ready_dmem_i) begin
                    valid_dmem_d = 1'b0;
                    state_d      = RESP;
                end
            end
            RESP: begin
                bus.valid_rsp_o[grant_q] = bus.valid_dmem_rsp_i;
                bus.ready_dmem_rsp_o     = bus.ready_rsp_i[grant_q];
                if (bus.valid_dmem_rsp_i && bus.ready_rsp_i[grant_q]) begin
`ifdef CPRV_DMEM_ARB_RR_EN
                    rr_ptr_d = ~grant_q;
`endif
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Keep every handshake output quiet while reset is asserted.
        if (rst) begin
            bus.ready_req_o      = '0;
            bus.valid_rsp_o      = '0;
            bus.ready_dmem_rsp_o = 1'b0;
        end
    end

    // State and registered dmem request outputs, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            valid_dmem_q <= 1'b0;
            w_en_q       <= OP_LOAD;
            addr_q       <= '0;
            wdata_q      <= '0;
`ifdef CPRV_DMEM_ARB_RR_EN
            rr_ptr_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            valid_dmem_q <= valid_dmem_d;
            w_en_q       <= w_en_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
`ifdef CPRV_DMEM_ARB_RR_EN
            rr_ptr_q     <= rr_ptr_d;
`endif
        end
    end

    assign bus.valid_dmem_o = valid_dmem_q;
    assign bus.addr_dmem_o  = addr_q;
    assign bus.wdata_dmem_o = wdata_q;
    assign bus.w_en_dmem_o  = w_en_q;
    // Read data is broadcast; only the granted port sees valid_rsp_o.
    assign bus.rdata_rsp_o  = bus.rdata_dmem_i;

endmodule

// File: tb/tb_cprv_dmem_arbiter.sv
// Directed self-checking bench for cprv_dmem_arbiter.
// Inputs change on the falling edge; outputs are checked 1 time unit later.
module tb_cprv_dmem_arbiter;
    import cprv_pkg::*;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;

    cprv_dmem_arbiter_if #(.DATA_WIDTH(64), .NUM_REQ(2)) bus ();

    cprv_dmem_arbiter #(.DATA_WIDTH(64), .NUM_REQ(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nedge();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        nedge();
        rst = 1'b1;
        nedge();
        nedge();
        rst = 1'b0;
    endtask

    // One contention transaction with both requesters valid; ready_dmem_i is already 1.
    task automatic contend(input logic exp_idx, input int n);
        logic [63:0] exp_addr;
        exp_addr = exp_idx ? 64'hB0 : 64'hA0;
        settle();
        chk($sformatf("cont%0d_ready_req", n), 64'(bus.ready_req_o), exp_idx ? 64'h2 : 64'h1);
        nedge();
        chk($sformatf("cont%0d_addr", n), bus.addr_dmem_o, exp_addr);
        nedge();
        bus.valid_dmem_rsp_i = 1'b1;
        bus.rdata_dmem_i     = 64'h100 + 64'(n);
        settle();
        chk($sformatf("cont%0d_valid_rsp", n), 64'(bus.valid_rsp_o), exp_idx ? 64'h2 : 64'h1);
        nedge();
        bus.valid_dmem_rsp_i = 1'b0;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b1;
        bus.valid_req_i      = '0;
        bus.addr_req_i       = '0;
        bus.wdata_req_i      = '0;
        bus.w_en_req_i       = '0;
        bus.ready_rsp_i      = 2'b11;
        bus.ready_dmem_i     = 1'b0;
        bus.valid_dmem_rsp_i = 1'b0;
        bus.rdata_dmem_i     = '0;

        // Reset state, with a request present that must not be accepted.
        nedge();
        nedge();
        bus.valid_req_i = 2'b01;
        settle();
        chk("rst_valid_dmem", 64'(bus.valid_dmem_o), 64'h0);
        chk("rst_ready_req", 64'(bus.ready_req_o), 64'h0);
        chk("rst_valid_rsp", 64'(bus.valid_rsp_o), 64'h0);
        chk("rst_ready_dmem_rsp", 64'(bus.ready_dmem_rsp_o), 64'h0);
        chk("rst_addr", bus.addr_dmem_o, 64'h0);
        chk("rst_wdata", bus.wdata_dmem_o, 64'h0);
        chk("rst_w_en", 64'(bus.w_en_dmem_o), 64'h0);
        chk("rst_state", 64'(dut.state_q), 64'(IDLE));
        bus.valid_req_i = 2'b00;
        rst = 1'b0;

        // Single load from port 0.
        nedge();
        bus.valid_req_i   = 2'b01;
        bus.addr_req_i[0] = 64'h1000;
        bus.w_en_req_i[0] = OP_LOAD;
        bus.ready_dmem_i  = 1'b1;
        settle();
        chk("ld_ready_req", 64'(bus.ready_req_o), 64'h1);
        nedge();
        bus.valid_req_i = 2'b00;
        settle();
        chk("ld_valid_dmem", 64'(bus.valid_dmem_o), 64'h1);
        chk("ld_addr", bus.addr_dmem_o, 64'h1000);
        chk("ld_w_en", 64'(bus.w_en_dmem_o), 64'h0);
        chk("ld_state_issue", 64'(dut.state_q), 64'(ISSUE));
        nedge();
        bus.valid_dmem_rsp_i = 1'b1;
        bus.rdata_dmem_i     = 64'hDEAD;
        settle();
        chk("ld_valid_dmem_low", 64'(bus.valid_dmem_o), 64'h0);
        chk("ld_valid_rsp", 64'(bus.valid_rsp_o), 64'h1);
        chk("ld_rdata", bus.rdata_rsp_o, 64'hDEAD);
        chk("ld_ready_dmem_rsp", 64'(bus.ready_dmem_rsp_o), 64'h1);
        nedge();
        bus.valid_dmem_rsp_i = 1'b0;
        settle();
        chk("ld_state_idle", 64'(dut.state_q), 64'(IDLE));

        // Contention, both requesters held valid for four transactions.
        do_reset();
        bus.valid_req_i   = 2'b11;
        bus.addr_req_i[0] = 64'hA0;
        bus.addr_req_i[1] = 64'hB0;
        bus.w_en_req_i    = 2'b00;
`ifdef CPRV_DMEM_ARB_RR_EN
        contend(1'b0, 0);
        contend(1'b1, 1);
        contend(1'b0, 2);
        contend(1'b1, 3);
`else
        contend(1'b0, 0);
        contend(1'b0, 1);
        contend(1'b0, 2);
        contend(1'b0, 3);
`endif
        bus.valid_req_i = 2'b00;

        // dmem stall on a port-0 store, then response backpressure in the same transaction.
        do_reset();
        bus.valid_req_i    = 2'b01;
        bus.addr_req_i[0]  = 64'h3000;
        bus.wdata_req_i[0] = 64'h77;
        bus.w_en_req_i[0]  = OP_STORE;
        bus.ready_dmem_i   = 1'b0;
        settle();
        chk("stall_ready_req", 64'(bus.ready_req_o), 64'h1);
        for (int i = 0; i < 5; i++) begin
            nedge();
            bus.valid_req_i    = 2'b11;
            bus.addr_req_i[0]  = 64'hFFFF;
            bus.wdata_req_i[0] = 64'h1234;
            settle();
            chk($sformatf("stall%0d_valid", i), 64'(bus.valid_dmem_o), 64'h1);
            chk($sformatf("stall%0d_addr", i), bus.addr_dmem_o, 64'h3000);
            chk($sformatf("stall%0d_wdata", i), bus.wdata_dmem_o, 64'h77);
            chk($sformatf("stall%0d_ready_req", i), 64'(bus.ready_req_o), 64'h0);
        end
        bus.ready_dmem_i = 1'b1;
        nedge();
        bus.ready_rsp_i      = 2'b10;
        bus.valid_dmem_rsp_i = 1'b1;
        bus.rdata_dmem_i     = 64'hBEEF;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk($sformatf("bp%0d_ready_dmem_rsp", i), 64'(bus.ready_dmem_rsp_o), 64'h0);
            chk($sformatf("bp%0d_valid_rsp", i), 64'(bus.valid_rsp_o), 64'h1);
            chk($sformatf("bp%0d_state", i), 64'(dut.state_q), 64'(RESP));
            chk($sformatf("bp%0d_ready_req", i), 64'(bus.ready_req_o), 64'h0);
            nedge();
        end
        bus.ready_rsp_i = 2'b11;
        settle();
        chk("bp_release_ready_dmem_rsp", 64'(bus.ready_dmem_rsp_o), 64'h1);
        nedge();
        bus.valid_req_i      = 2'b00;
        bus.valid_dmem_rsp_i = 1'b0;
        settle();
        chk("bp_state_idle", 64'(dut.state_q), 64'(IDLE));

        // Store from port 1.
        nedge();
        bus.valid_req_i    = 2'b10;
        bus.addr_req_i[1]  = 64'h2008;
        bus.wdata_req_i[1] = 64'h55AA;
        bus.w_en_req_i[1]  = OP_STORE;
        bus.ready_dmem_i   = 1'b1;
        settle();
        chk("st_ready_req", 64'(bus.ready_req_o), 64'h2);
        nedge();
        bus.valid_req_i = 2'b00;
        settle();
        chk("st_w_en", 64'(bus.w_en_dmem_o), 64'h1);
        chk("st_addr", bus.addr_dmem_o, 64'h2008);
        chk("st_wdata", bus.wdata_dmem_o, 64'h55AA);
        nedge();
        bus.valid_dmem_rsp_i = 1'b1;
        settle();
        chk("st_valid_rsp", 64'(bus.valid_rsp_o), 64'h2);
        chk("st_ready_dmem_rsp", 64'(bus.ready_dmem_rsp_o), 64'h1);
        nedge();
        bus.valid_dmem_rsp_i = 1'b0;
        settle();
        chk("st_state_idle", 64'(dut.state_q), 64'(IDLE));

        // Reset while in ISSUE, then a fresh request.
        nedge();
        bus.valid_req_i   = 2'b01;
        bus.addr_req_i[0] = 64'h4000;
        bus.w_en_req_i[0] = OP_LOAD;
        bus.ready_dmem_i  = 1'b0;
        nedge();
        bus.valid_req_i = 2'b00;
        settle();
        chk("ri_state_issue", 64'(dut.state_q), 64'(ISSUE));
        rst = 1'b1;
        nedge();
        rst = 1'b0;
        settle();
        chk("ri_valid_dmem", 64'(bus.valid_dmem_o), 64'h0);
        chk("ri_state_idle", 64'(dut.state_q), 64'(IDLE));
        nedge();
        bus.valid_req_i   = 2'b01;
        bus.addr_req_i[0] = 64'h5000;
        bus.ready_dmem_i  = 1'b1;
        settle();
        chk("ri_fresh_ready_req", 64'(bus.ready_req_o), 64'h1);
        nedge();
        bus.valid_req_i = 2'b00;
        settle();
        chk("ri_fresh_valid_dmem", 64'(bus.valid_dmem_o), 64'h1);
        chk("ri_fresh_addr", bus.addr_dmem_o, 64'h5000);
        nedge();
        bus.valid_dmem_rsp_i = 1'b1;
        settle();
        chk("ri_fresh_valid_rsp", 64'(bus.valid_rsp_o), 64'h1);
        nedge();
        bus.valid_dmem_rsp_i = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cprv_dmem_arbiter.md
Name: cprv_dmem_arbiter

Overview:
- Shares one data-memory port between two requesters. Port 0 is the mem stage; port 1 is a secondary master such as a debug or DMA agent.
- Sequences each access through an FSM with exactly one transaction outstanding: grant, request issue, response return.
- Sits between the requesters and the dmem. Uses the valid/ready request and response channels of the pipeline's dmem interface.

Parameters:
- DATA_WIDTH, 64, width of address, write data and read data.
- NUM_REQ, 2, number of requesters; fixed at 2 in this revision.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- valid_req_i  in  2  request valid, one bit per requester.
- ready_req_o  out  2  request accepted, one bit per requester.
- addr_req_i  in  2xDATA_WIDTH  request address, per requester.
- wdata_req_i  in  2xDATA_WIDTH  store data, per requester.
- w_en_req_i  in  2  1 = store, 0 = load.
- valid_rsp_o  out  2  response valid, per requester.
- ready_rsp_i  in  2  requester can take the response.
- rdata_rsp_o  out  DATA_WIDTH  response data, broadcast to both requesters.
- valid_dmem_o  out  1  request to dmem.
- ready_dmem_i  in  1  dmem accepts the request.
- addr_dmem_o  out  DATA_WIDTH  request address to dmem.
- wdata_dmem_o  out  DATA_WIDTH  store data to dmem.
- w_en_dmem_o  out  1  store enable to dmem.
- valid_dmem_rsp_i  in  1  dmem response valid; asserted for both loads and stores.
- ready_dmem_rsp_o  out  1  arbiter can take the dmem response.
- rdata_dmem_i  in  DATA_WIDTH  dmem read data.

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous, active-high, and overrides everything.
- Reset values: FSM=IDLE, grant=0, rr_ptr=0, valid_dmem_o=0, w_en_dmem_o=0, addr/wdata_dmem_o=0, ready_req_o=0, valid_rsp_o=0, ready_dmem_rsp_o=0.
- FSM states are IDLE, ISSUE and RESP.
- IDLE:
  - If any valid_req_i is set, pick the winner and assert ready_req_o[winner] combinationally in the same cycle.
  - On the clock edge, latch addr/wdata/w_en into the dmem output registers, set valid_dmem_o=1, store grant=winner, and go to ISSUE.
  - The loser sees ready_req_o=0 and must hold its request.
- ISSUE:
  - valid_dmem_o is held at 1 and the payload is held stable.
  - On valid_dmem_o & ready_dmem_i, clear valid_dmem_o and go to RESP.
- RESP:
  - valid_rsp_o[grant] = valid_dmem_rsp_i.
  - ready_dmem_rsp_o = ready_rsp_i[grant].
  - rdata_rsp_o = rdata_dmem_i.
  - On the response handshake, update rr_ptr to ~grant and go to IDLE.
- Outside RESP: ready_dmem_rsp_o=0 and valid_rsp_o=0. A dmem response arriving early is held by the dmem.
- ready_req_o is 0 in ISSUE and RESP, so no new request is accepted while one is outstanding.
- Arbitration: fixed priority, port 0 wins when both requesters are valid. Round-robin applies only with the optional feature below.
- Latency: request accepted in cycle N, valid_dmem_o high in cycle N+1.
- Minimum period is 3 cycles per transaction: IDLE, ISSUE with ready_dmem_i=1, RESP with the response present.
- Simultaneous events: ready_dmem_i high in the first ISSUE cycle means a 1-cycle ISSUE. Response backpressure (ready_rsp_i=0) keeps the FSM in RESP indefinitely.
- Reset mid-transaction: the FSM returns to IDLE and valid_dmem_o drops. Any in-flight dmem response is dropped by the system-level reset of the dmem.
- Payload from the requester is sampled only at the accept edge. Later changes on the requester inputs do not affect the dmem outputs.

Optional Feature:
- Macro: CPRV_DMEM_ARB_RR_EN.
- Defined: round-robin arbitration. When both requesters are valid, the port equal to rr_ptr wins. rr_ptr flips to the non-granted port after each completed response.
- Undefined: fixed priority with port 0 highest. rr_ptr is not implemented.

Decomposition:
- Package cprv_pkg holds:
  - typedef enum logic [1:0] {IDLE, ISSUE, RESP} dmem_arb_state_t;
  - the LOAD/STORE opcode constants shared with the pipeline stages.
- Sub-module cprv_arb_pick: combinational 2-way picker.
  - Inputs: valid vector, rr_ptr.
  - Outputs: one-hot grant and grant index.
  - Contains the RR/fixed selection under the macro.

Test Plan:
- Single load: valid_req_i=01, addr=0x1000, ready_dmem_i=1, response 0xDEAD 1 cycle later -> valid_dmem_o at cycle 1 with addr 0x1000, w_en=0; valid_rsp_o=01 with rdata 0xDEAD; back in IDLE at cycle 3.
- Contention: valid_req_i=11 held continuously, 4 transactions.
  - Fixed priority: grants 0,0,0,0.
  - With RR_EN: grants 0,1,0,1.
- dmem stall: ready_dmem_i=0 for 5 cycles -> valid_dmem_o stays 1 with addr/wdata stable; ready_req_o=00 throughout.
- Response backpressure: ready_rsp_i[0]=0 for 3 cycles while valid_dmem_rsp_i=1 -> ready_dmem_rsp_o=0; FSM stays in RESP; no new grant.
- Store from port 1: addr 0x2008, wdata 0x55AA, w_en=1 -> w_en_dmem_o=1 with that data; completion is delivered on valid_rsp_o[1].
- Reset in ISSUE: assert rst for 1 cycle -> next cycle valid_dmem_o=0, FSM=IDLE; a fresh request is accepted afterwards.
